vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised VGA raster generator: programmable H/V timing, sync polarity, RGB depth
//   and framebuffer read latency. Replaces the fixed 640x480 mono screen driver.
// - Counters run ahead of the display by LATENCY cycles and drive fetch_x/fetch_y to video RAM.
//   Syncs, blanking and coordinates are delayed to line up with returned pixel data.
// - Sits between the framebuffer RAM and the VGA DAC pins.
// PARAMETERS
// - H_VISIBLE  640  active pixels per line
// - H_FRONT    16   horizontal front porch, in pixels
// - H_SYNC     96   horizontal sync pulse, in pixels
// - H_BACK     48   horizontal back porch, in pixels
// - V_VISIBLE  480  active lines per frame
// - V_FRONT    10   vertical front porch, in lines
// - V_SYNC     2    vertical sync pulse, in lines
// - V_BACK     33   vertical back porch, in lines
// - H_POL      0    Hsync active level (0 = active-low)
// - V_POL      0    Vsync active level
// - R_W / G_W / B_W  3 / 3 / 2  colour channel widths
// - LATENCY    2    framebuffer read latency in cycles; 0..8 allowed
// - CNT_W      11   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// - VGA_clk    in   1              pixel clock
// - reset      in   1              asynchronous, active-high
// - enable     in   1              0: raster held at origin, outputs blanked
// - mono_en    in   1              1: pix_rgb[0] expands to full white or black
// - pix_rgb    in   R_W+G_W+B_W    pixel from RAM, {R,G,B}, valid LATENCY cycles after fetch
// - fetch_x    out  CNT_W          lookahead horizontal counter (RAM address X)
// - fetch_y    out  CNT_W          lookahead vertical counter (RAM address Y)
// - fetch_en   out  1              fetch_x/fetch_y lie inside the visible area
// - Hsync      out  1              horizontal sync, polarity H_POL
// - Vsync      out  1              vertical sync, polarity V_POL
// - R / G / B  out  R_W / G_W / B_W  colour outputs, 0 when blanked
// - X_screen   out  CNT_W          displayed pixel X, aligned with R/G/B
// - Y_screen   out  CNT_W          displayed pixel Y, aligned with R/G/B
// - line_start out  1              1-cycle pulse, aligned, on the first pixel of every line
// - frame_start out 1              1-cycle pulse, aligned, on pixel (0,0)
// BEHAVIOUR
// - Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined the same way.
// - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
// - v_cnt increments only on the h wrap. It wraps to 0 when the h wrap and v_cnt == V_TOTAL-1 coincide.
// - Phase per axis:
//   ACTIVE: cnt < VIS; FRONT: cnt < VIS+FRONT; SYNC: cnt < VIS+FRONT+SYNC; BACK otherwise.
//   Sync is at its active level only in SYNC.
// - fetch_x = h_cnt and fetch_y = v_cnt (registered counters); fetch_en = both axes ACTIVE.
// - Delay line, depth LATENCY: carries Hsync, Vsync, visible, line/frame flags and coordinates.
//   Its output stage is registered together with pix_rgb.
//   Counter state at cycle t appears on outputs in cycle t+LATENCY+1.
// - pix_rgb is sampled at the end of cycle t+LATENCY.
// - Colour: visible -> pix_rgb, or in mono mode all-ones/all-zeros from pix_rgb[0]; otherwise 0.
//   mono_en is sampled together with pix_rgb.
// - Reset and enable = 0 state:
//   counters 0; pipeline cleared; Hsync = ~H_POL, Vsync = ~V_POL; R/G/B 0; pulses 0; coords 0.
// - enable = 0 forces this state synchronously.
//   First cycle with enable = 1: counters at (0,0). After LATENCY+1 cycles: frame_start and line_start.
// - Reset mid-frame aborts the frame immediately (asynchronous). No partial-line recovery.
// - mono_en or pix_rgb changes apply per pixel with no glitch filtering.
// STRUCTURE
// - Shared package vga_timing_pkg:
//   phase enum (ACTIVE, FRONT, SYNC, BACK);
//   default 640x480@60 constants; 800x600 constant set.
// - Sub-module vga_axis_counter (VIS, FRONT, SYNC, BACK, POL, CNT_W):
//   inputs clk, reset, clr, ce; outputs cnt, phase, sync, wrap.
//   Instantiated twice: H with ce = 1, V with ce = H wrap.
// - Top level holds the alignment shift register and the colour output register.
// TESTING
// - Reset: hold reset 5 cycles, then release with enable = 0.
//   -> Hsync = 1, Vsync = 1, RGB = 0, fetch = (0,0) for 100 cycles.
// - Default line timing, LATENCY = 0:
//   -> Hsync low for exactly 96 cycles, falling edge 656 cycles after line_start;
//      line period 800 cycles.
// - Frame timing:
//   -> Vsync low across lines 490-491;
//      frame_start period 420000 cycles;
//      line_start count per frame 525.
// - Latency alignment, LATENCY = 3, model RAM returns {x[2:0], y[2:0], x[1:0]} after 3 cycles:
//   -> R/G/B always match the X_screen/Y_screen formula; RGB = 0 outside the visible area.
// - Mono and polarity, small timing (8/2/2/2 x 4/1/1/1), H_POL = 1, mono_en = 1, pix_rgb[0] = 1:
//   -> RGB = 8'hFF while visible; Hsync high 2 cycles per 14-cycle line.
// - Reset mid-frame at (300,200), then disable/enable:
//   -> outputs return to reset values immediately;
//      after release, frame_start comes LATENCY+1 cycles after the first enable = 1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster types and standard mode constants.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_t;

  localparam int   VGA640_H_VISIBLE = 640;
  localparam int   VGA640_H_FRONT   = 16;
  localparam int   VGA640_H_SYNC    = 96;
  localparam int   VGA640_H_BACK    = 48;
  localparam int   VGA640_V_VISIBLE = 480;
  localparam int   VGA640_V_FRONT   = 10;
  localparam int   VGA640_V_SYNC    = 2;
  localparam int   VGA640_V_BACK    = 33;
  localparam logic VGA640_H_POL     = 1'b0;
  localparam logic VGA640_V_POL     = 1'b0;

  localparam int   SVGA800_H_VISIBLE = 800;
  localparam int   SVGA800_H_FRONT   = 40;
  localparam int   SVGA800_H_SYNC    = 128;
  localparam int   SVGA800_H_BACK    = 88;
  localparam int   SVGA800_V_VISIBLE = 600;
  localparam int   SVGA800_V_FRONT   = 1;
  localparam int   SVGA800_V_SYNC    = 4;
  localparam int   SVGA800_V_BACK    = 23;
  localparam logic SVGA800_H_POL     = 1'b1;
  localparam logic SVGA800_V_POL     = 1'b1;

  function automatic int total(
    input int vis,
    input int front,
    input int sync,
    input int back
  );
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with phase decode and sync level.
module vga_axis_counter #(
  parameter int   VIS   = 640,
  parameter int   FRONT = 16,
  parameter int   SYNC  = 96,
  parameter int   BACK  = 48,
  parameter logic POL   = 1'b0,
  parameter int   CNT_W = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   ce,
  output logic [CNT_W-1:0]       cnt,
  output vga_timing_pkg::phase_t phase,
  output logic                   sync,
  output logic                   wrap
);

  localparam int TOTAL =
    vga_timing_pkg::total(VIS, FRONT, SYNC, BACK);

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] F_BEG = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] S_BEG = CNT_W'(VIS + FRONT);
  localparam logic [CNT_W-1:0] B_BEG = CNT_W'(VIS + FRONT + SYNC);

  assign wrap = ce && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (wrap) cnt <= '0;
    else if (ce)   cnt <= cnt + CNT_W'(1);
  end

  always_comb begin
    phase = vga_timing_pkg::BACK;
    unique case (1'b1)
      cnt < F_BEG:
        phase = vga_timing_pkg::ACTIVE;
      cnt >= F_BEG && cnt < S_BEG:
        phase = vga_timing_pkg::FRONT;
      cnt >= S_BEG && cnt < B_BEG:
        phase = vga_timing_pkg::SYNC;
      cnt >= B_BEG:
        phase = vga_timing_pkg::BACK;
    endcase
  end

  assign sync = (phase == vga_timing_pkg::SYNC) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: lookahead fetch counters, then syncs and
// coordinates delayed to line up with the pixel returned by video RAM.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = VGA640_H_VISIBLE,
  parameter int   H_FRONT   = VGA640_H_FRONT,
  parameter int   H_SYNC    = VGA640_H_SYNC,
  parameter int   H_BACK    = VGA640_H_BACK,
  parameter int   V_VISIBLE = VGA640_V_VISIBLE,
  parameter int   V_FRONT   = VGA640_V_FRONT,
  parameter int   V_SYNC    = VGA640_V_SYNC,
  parameter int   V_BACK    = VGA640_V_BACK,
  parameter logic H_POL     = VGA640_H_POL,
  parameter logic V_POL     = VGA640_V_POL,
  parameter int   R_W       = 3,
  parameter int   G_W       = 3,
  parameter int   B_W       = 2,
  parameter int   LATENCY   = 2,
  parameter int   CNT_W     = 11
) (
  input  logic                     VGA_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mono_en,
  input  logic [R_W+G_W+B_W-1:0]   pix_rgb,
  output logic [CNT_W-1:0]         fetch_x,
  output logic [CNT_W-1:0]         fetch_y,
  output logic                     fetch_en,
  output logic                     Hsync,
  output logic                     Vsync,
  output logic [R_W-1:0]           R,
  output logic [G_W-1:0]           G,
  output logic [B_W-1:0]           B,
  output logic [CNT_W-1:0]         X_screen,
  output logic [CNT_W-1:0]         Y_screen,
  output logic                     line_start,
  output logic                     frame_start
);

  localparam int PIX_W = R_W + G_W + B_W;

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             vis;
    logic             ls;
    logic             fs;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } tap_t;

  localparam tap_t IDLE = '{
    hs:  ~H_POL,
    vs:  ~V_POL,
    vis: 1'b0,
    ls:  1'b0,
    fs:  1'b0,
    x:   '0,
    y:   '0
  };

  phase_t h_phase;
  phase_t v_phase;
  logic   h_sync;
  logic   v_sync;
  logic   h_wrap;
  logic   unused_v_wrap;

  vga_axis_counter #(
    .VIS   (H_VISIBLE),
    .FRONT (H_FRONT),
    .SYNC  (H_SYNC),
    .BACK  (H_BACK),
    .POL   (H_POL),
    .CNT_W (CNT_W)
  ) u_h (
    .clk   (VGA_clk),
    .reset (reset),
    .clr   (~enable),
    .ce    (1'b1),
    .cnt   (fetch_x),
    .phase (h_phase),
    .sync  (h_sync),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .VIS   (V_VISIBLE),
    .FRONT (V_FRONT),
    .SYNC  (V_SYNC),
    .BACK  (V_BACK),
    .POL   (V_POL),
    .CNT_W (CNT_W)
  ) u_v (
    .clk   (VGA_clk),
    .reset (reset),
    .clr   (~enable),
    .ce    (h_wrap),
    .cnt   (fetch_y),
    .phase (v_phase),
    .sync  (v_sync),
    .wrap  (unused_v_wrap)
  );

  assign fetch_en = enable
                 && h_phase == ACTIVE
                 && v_phase == ACTIVE;

  tap_t tap;
  tap_t dly;

  assign tap = '{
    hs:  h_sync,
    vs:  v_sync,
    vis: fetch_en,
    ls:  fetch_x == '0,
    fs:  fetch_x == '0 && fetch_y == '0,
    x:   fetch_x,
    y:   fetch_y
  };

  // Matches the RAM read latency so dly pairs with pix_rgb.
  generate
    if (LATENCY == 0) begin : g_direct
      assign dly = tap;
    end else begin : g_pipe
      tap_t pipe [LATENCY];
      always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY; i++)
            pipe[i] <= IDLE;
        end else begin
          pipe[0] <= enable ? tap : IDLE;
          for (int i = 1; i < LATENCY; i++)
            pipe[i] <= enable ? pipe[i-1] : IDLE;
        end
      end
      assign dly = pipe[LATENCY-1];
    end
  endgenerate

  tap_t             o_d;
  logic [PIX_W-1:0] rgb_d;
  logic [PIX_W-1:0] rgb_q;

  assign o_d = enable ? dly : IDLE;

  always_comb begin
    rgb_d = '0;
    if (o_d.vis)
      rgb_d = mono_en ? {PIX_W{pix_rgb[0]}} : pix_rgb;
  end

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      Hsync       <= IDLE.hs;
      Vsync       <= IDLE.vs;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      X_screen    <= '0;
      Y_screen    <= '0;
      rgb_q       <= '0;
    end else begin
      Hsync       <= o_d.hs;
      Vsync       <= o_d.vs;
      line_start  <= o_d.ls;
      frame_start <= o_d.fs;
      X_screen    <= o_d.x;
      Y_screen    <= o_d.y;
      rgb_q       <= rgb_d;
    end
  end

  assign {R, G, B} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 line timing, small-raster alignment,
// mono/polarity, and mid-frame reset behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A: default 640x480, LATENCY 0
  logic        a_rst, a_en, a_mono;
  logic [7:0]  a_pix;
  logic [10:0] a_fx, a_fy, a_X, a_Y;
  logic        a_fen, a_hs, a_vs, a_ls, a_fs;
  logic [2:0]  a_r, a_g;
  logic [1:0]  a_b;
  logic [7:0]  a_rgb;
  assign a_rgb = {a_r, a_g, a_b};

  vga_timing_gen #(.LATENCY(0)) ua (
    .VGA_clk(clk), .reset(a_rst), .enable(a_en),
    .mono_en(a_mono), .pix_rgb(a_pix),
    .fetch_x(a_fx), .fetch_y(a_fy), .fetch_en(a_fen),
    .Hsync(a_hs), .Vsync(a_vs), .R(a_r), .G(a_g), .B(a_b),
    .X_screen(a_X), .Y_screen(a_Y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  // B: 8/2/2/2 x 4/1/1/1, LATENCY 3, model RAM
  logic        b_rst, b_en, b_mono;
  logic [7:0]  b_pix;
  logic [10:0] b_fx, b_fy, b_X, b_Y;
  logic        b_fen, b_hs, b_vs, b_ls, b_fs;
  logic [2:0]  b_r, b_g;
  logic [1:0]  b_b;
  logic [7:0]  b_rgb;
  assign b_rgb = {b_r, b_g, b_b};

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .LATENCY(3)
  ) ub (
    .VGA_clk(clk), .reset(b_rst), .enable(b_en),
    .mono_en(b_mono), .pix_rgb(b_pix),
    .fetch_x(b_fx), .fetch_y(b_fy), .fetch_en(b_fen),
    .Hsync(b_hs), .Vsync(b_vs), .R(b_r), .G(b_g), .B(b_b),
    .X_screen(b_X), .Y_screen(b_Y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  logic [7:0] ram_q [3];
  always @(posedge clk) begin
    ram_q[0] <= {b_fx[2:0], b_fy[2:0], b_fx[1:0]};
    ram_q[1] <= ram_q[0];
    ram_q[2] <= ram_q[1];
  end
  assign b_pix = ram_q[2];

  // C: small raster, H_POL 1, LATENCY 2, mono
  logic        c_rst, c_en, c_mono;
  logic [7:0]  c_pix;
  logic [10:0] c_fx, c_fy, c_X, c_Y;
  logic        c_fen, c_hs, c_vs, c_ls, c_fs;
  logic [2:0]  c_r, c_g;
  logic [1:0]  c_b;
  logic [7:0]  c_rgb;
  assign c_rgb = {c_r, c_g, c_b};

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .LATENCY(2)
  ) uc (
    .VGA_clk(clk), .reset(c_rst), .enable(c_en),
    .mono_en(c_mono), .pix_rgb(c_pix),
    .fetch_x(c_fx), .fetch_y(c_fy), .fetch_en(c_fen),
    .Hsync(c_hs), .Vsync(c_vs), .R(c_r), .G(c_g), .B(c_b),
    .X_screen(c_X), .Y_screen(c_Y),
    .line_start(c_ls), .frame_start(c_fs)
  );

  typedef struct {
    int          k;
    logic        hs, vs, ls, fs;
    logic [10:0] x, y;
    logic [7:0]  rgb;
  } vec_t;

  function automatic vec_t mk(input int k, input logic hs,
                              input logic vs, input logic ls,
                              input logic fs, input int x,
                              input int y, input logic [7:0] rgb);
    vec_t v;
    v.k = k; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
    v.x = 11'(x); v.y = 11'(y); v.rgb = rgb;
    return v;
  endfunction

  vec_t        tbl [17];
  int          cur, j, e1, e2, e3, e4, e5, e6, e7, n1, n2;
  int          t_ls1, t_ls2, t_fs1, t_hsf, hs_low;
  logic        prev_hs, vis;
  logic [10:0] ex, ey, fx, fy;
  logic [7:0]  erg;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // k = cycles after enable; output shows counter state k-4
    tbl[0]  = mk(1,   1, 1, 0, 0, 0,  0, 8'h00);
    tbl[1]  = mk(3,   1, 1, 0, 0, 0,  0, 8'h00);
    tbl[2]  = mk(4,   1, 1, 1, 1, 0,  0, 8'h00);
    tbl[3]  = mk(5,   1, 1, 0, 0, 1,  0, 8'h21);
    tbl[4]  = mk(11,  1, 1, 0, 0, 7,  0, 8'hE3);
    tbl[5]  = mk(12,  1, 1, 0, 0, 8,  0, 8'h00);
    tbl[6]  = mk(14,  0, 1, 0, 0, 10, 0, 8'h00);
    tbl[7]  = mk(15,  0, 1, 0, 0, 11, 0, 8'h00);
    tbl[8]  = mk(16,  1, 1, 0, 0, 12, 0, 8'h00);
    tbl[9]  = mk(18,  1, 1, 1, 0, 0,  1, 8'h04);
    tbl[10] = mk(37,  1, 1, 0, 0, 5,  2, 8'hA9);
    tbl[11] = mk(52,  1, 1, 0, 0, 6,  3, 8'hCE);
    tbl[12] = mk(63,  1, 1, 0, 0, 3,  4, 8'h00);
    tbl[13] = mk(74,  1, 0, 1, 0, 0,  5, 8'h00);
    tbl[14] = mk(99,  0, 1, 0, 0, 11, 6, 8'h00);
    tbl[15] = mk(102, 1, 1, 1, 1, 0,  0, 8'h00);
    tbl[16] = mk(103, 1, 1, 0, 0, 1,  0, 8'h21);

    a_rst = 1; b_rst = 1; c_rst = 1;
    a_en = 0; b_en = 0; c_en = 0;
    a_mono = 0; b_mono = 0; c_mono = 1;
    a_pix = 8'h5A; c_pix = 8'h01;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_hold_a",
        {a_hs, a_vs, a_rgb, a_fx, a_fy, a_ls, a_fs},
        {1'b1, 1'b1, 8'h00, 11'd0, 11'd0, 1'b0, 1'b0});
    a_rst = 0; b_rst = 0; c_rst = 0;

    e1 = 0; e2 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ({a_hs, a_vs, a_rgb, a_fx, a_fy} !==
          {1'b1, 1'b1, 8'h00, 11'd0, 11'd0}) e1++;
      if ({c_hs, c_vs, c_rgb} !== {1'b0, 1'b1, 8'h00}) e2++;
    end
    chk("reset_idle_100", e1, 0);
    chk("idle_hpol1", e2, 0);

    // default line timing
    a_en = 1;
    t_ls1 = -1; t_ls2 = -1; t_fs1 = -1; t_hsf = -1;
    hs_low = 0; e1 = 0; prev_hs = 1;
    for (int k = 1; k <= 900; k++) begin
      @(negedge clk);
      if (a_fs && t_fs1 < 0) t_fs1 = k;
      if (a_ls) begin
        if (t_ls1 < 0) t_ls1 = k;
        else if (t_ls2 < 0) t_ls2 = k;
      end
      if (t_ls1 >= 0 && t_ls2 < 0) begin
        if (!a_hs) hs_low++;
        if (prev_hs && !a_hs && t_hsf < 0) t_hsf = k;
        erg = (a_X < 11'd640) ? 8'h5A : 8'h00;
        if (a_rgb !== erg) e1++;
      end
      prev_hs = a_hs;
    end
    chk("a_first_line_start", t_ls1, 1);
    chk("a_first_frame_start", t_fs1, 1);
    chk("a_hsync_fall_offset", t_hsf - t_ls1, 656);
    chk("a_hsync_low_width", hs_low, 96);
    chk("a_line_period", t_ls2 - t_ls1, 800);
    chk("a_rgb_blanking", e1, 0);

    // latency alignment table
    @(negedge clk);
    b_en = 1; cur = 0;
    for (int i = 0; i < 17; i++) begin
      repeat (tbl[i].k - cur) @(negedge clk);
      cur = tbl[i].k;
      chk($sformatf("vec%0d_k%0d", i, tbl[i].k),
          {b_hs, b_vs, b_ls, b_fs, b_X, b_Y, b_rgb},
          {tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs,
           tbl[i].x, tbl[i].y, tbl[i].rgb});
    end

    // two full frames
    e1 = 0; e2 = 0; e3 = 0; e4 = 0; e5 = 0; e6 = 0; n1 = 0; n2 = 0;
    for (int k = 104; k < 300; k++) begin
      @(negedge clk);
      j = k - 4;
      ex = 11'(j % 14); ey = 11'((j / 14) % 7);
      fx = 11'(k % 14); fy = 11'((k / 14) % 7);
      vis = ex < 11'd8 && ey < 11'd4;
      erg = vis ? {ex[2:0], ey[2:0], ex[1:0]} : 8'h00;
      if (b_X !== ex || b_Y !== ey) e1++;
      if (b_rgb !== erg) e2++;
      if (b_hs !== !(ex == 11'd10 || ex == 11'd11)) e3++;
      if (b_vs !== (ey != 11'd5)) e4++;
      if (b_fx !== fx || b_fy !== fy ||
          b_fen !== (fx < 11'd8 && fy < 11'd4)) e5++;
      if (b_fs !== (j % 98 == 0)) e6++;
      if (b_ls) n1++;
      if (b_fs) n2++;
    end
    chk("b_coords", e1, 0);
    chk("b_rgb_formula", e2, 0);
    chk("b_hsync_pos", e3, 0);
    chk("b_vsync_line5", e4, 0);
    chk("b_fetch", e5, 0);
    chk("b_frame_start_pos", e6, 0);
    chk("b_line_starts_2fr", n1, 14);
    chk("b_frame_starts_2fr", n2, 2);

    // mid-frame reset
    e1 = 0;
    for (int k = 0; k < 200 && e1 == 0; k++) begin
      @(negedge clk);
      if (b_fx == 11'd5 && b_fy == 11'd2) e1 = 1;
    end
    chk("mf_reach", e1, 1);
    b_rst = 1; b_en = 0;
    #1;
    chk("mf_async_idle",
        {b_hs, b_vs, b_ls, b_fs, b_X, b_Y, b_rgb, b_fx, b_fy},
        {1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 8'h00, 11'd0, 11'd0});
    repeat (2) @(negedge clk);
    b_rst = 0;
    repeat (3) @(negedge clk);
    chk("mf_disabled_idle",
        {b_hs, b_vs, b_ls, b_fs, b_X, b_Y, b_rgb, b_fx, b_fy},
        {1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 8'h00, 11'd0, 11'd0});
    b_en = 1;
    t_fs1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b_fs && t_fs1 < 0) t_fs1 = k;
    end
    chk("mf_restart_latency", t_fs1, 4);

    // mono and Hsync polarity
    c_en = 1;
    e1 = 0; e2 = 0; e3 = 0; e4 = 0; n1 = 0; t_fs1 = -1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        j = k - 3;
        ex = 11'(j % 14); ey = 11'((j / 14) % 7);
      end else begin
        ex = 11'd0; ey = 11'd5;
      end
      vis = ex < 11'd8 && ey < 11'd4;
      if (c_hs !== (ex == 11'd10 || ex == 11'd11)) e1++;
      if (c_fs && t_fs1 < 0) t_fs1 = k;
      if (k >= 3 && k <= 100) begin
        if (c_hs) n1++;
        if (c_rgb !== (vis ? 8'hFF : 8'h00)) e2++;
      end
      if (k >= 105 && k <= 118 && c_rgb !== 8'h00) e3++;
      if (k >= 125 && c_rgb !== (vis ? 8'hFE : 8'h00)) e4++;
      if (k == 100) c_pix = 8'hFE;
      if (k == 120) c_mono = 0;
    end
    chk("c_hsync_pol_pos", e1, 0);
    chk("c_hsync_high_frame", n1, 14);
    chk("c_frame_start_lat", t_fs1, 3);
    chk("c_mono_white", e2, 0);
    chk("c_mono_black", e3, 0);
    chk("c_color_passthru", e4, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
